// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer definitions.
//   Default geometry and widths, the frame size, pixel/address types and the
//   arbiter state type used by fb_arbiter and fb_addr_gen.
package fb_pkg;

   localparam int unsigned FB_H_ACTIVE = 640;
   localparam int unsigned FB_V_ACTIVE = 480;
   localparam int unsigned FB_ADDR_W   = 19;
   localparam int unsigned FB_DATA_W   = 8;
   localparam int unsigned FB_PIXELS   = FB_H_ACTIVE * FB_V_ACTIVE;

   typedef logic [FB_DATA_W-1:0] pixel_t;
   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef enum logic {
      IDLE,
      CLEAR
   } fb_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: combinational scan position to linear framebuffer address.
//   hcount, vcount : current column / line
//   addr           : vcount*H_ACTIVE + hcount at ADDR_W width
//   active         : position lies inside the visible area
module fb_addr_gen import fb_pkg::*; #(
   parameter int unsigned H_ACTIVE = FB_H_ACTIVE,
   parameter int unsigned V_ACTIVE = FB_V_ACTIVE,
   parameter int unsigned ADDR_W   = FB_ADDR_W
) (
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   output logic [ADDR_W-1:0] addr,
   output logic              active
);

   always_comb begin
      active = (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
      addr   = ADDR_W'(vcount) * ADDR_W'(H_ACTIVE) + ADDR_W'(hcount);
   end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter.
//   Display reads (pix_en inside the active area) own the RAM port every
//   cycle they occur; all other cycles are write slots used either by the
//   pixel writer (wr_req/wr_ack) or by the full-frame clear sequencer.
//   clk, reset      : clock, synchronous active-high reset
//   pix_en, hcount, vcount : pixel strobe and scan position
//   pix_color       : registered display colour, 2 cycles after the strobe
//   wr_req/addr/data, wr_ack : writer request, one-cycle ack on grant
//   clear_start/color, clear_busy, clear_done : hardware fill control
//   mem_addr/we/wdata/rdata  : RAM port (read data 1 cycle after address)
module fb_arbiter import fb_pkg::*; #(
   parameter int unsigned H_ACTIVE = FB_H_ACTIVE,
   parameter int unsigned V_ACTIVE = FB_V_ACTIVE,
   parameter int unsigned ADDR_W   = FB_ADDR_W,
   parameter int unsigned DATA_W   = FB_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   output logic [DATA_W-1:0] pix_color,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned       PIXELS    = H_ACTIVE * V_ACTIVE;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   fb_state_e         state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] clr_color;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_active;
   logic              disp_slot;
   logic              wr_in_range;
   logic              clr_step;
   logic              clr_accept;
   logic              done_nxt;
   logic              rd_pend;
   logic              blank_pend;

   fb_addr_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .hcount (hcount),
      .vcount (vcount),
      .addr   (disp_addr),
      .active (disp_active)
   );

   // One extra bit so a frame filling the whole address space still compares.
   assign wr_in_range = {1'b0, wr_addr} < (ADDR_W + 1)'(PIXELS);
   assign disp_slot   = pix_en & disp_active;

   always_comb begin
      state_nxt  = state;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      wr_ack     = 1'b0;
      clr_step   = 1'b0;
      clr_accept = 1'b0;
      done_nxt   = 1'b0;
      clear_busy = (state == CLEAR);

      if (!reset) begin
         if (disp_slot) begin
            mem_addr = disp_addr;
         end else begin
            case (state)
               IDLE: begin
                  if (wr_req) begin
                     wr_ack = 1'b1;
                     if (wr_in_range) begin
                        mem_addr  = wr_addr;
                        mem_we    = 1'b1;
                        mem_wdata = wr_data;
                     end
                  end
               end
               CLEAR: begin
                  mem_addr  = clr_cnt;
                  mem_we    = 1'b1;
                  mem_wdata = clr_color;
                  clr_step  = 1'b1;
                  if (clr_cnt == LAST_ADDR) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // A clear may be accepted in any IDLE cycle, alongside a writer grant.
         if (state == IDLE && clear_start) begin
            state_nxt  = CLEAR;
            clr_accept = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         clr_color  <= '0;
         clear_done <= 1'b0;
         rd_pend    <= 1'b0;
         blank_pend <= 1'b0;
         pix_color  <= '0;
      end else begin
         state      <= state_nxt;
         clear_done <= done_nxt;
         rd_pend    <= disp_slot;
         blank_pend <= pix_en & ~disp_active;

         // RAM data arrives the cycle after the read address; blanking is
         // delayed by the same amount so both paths share the 2-cycle latency.
         if (rd_pend) begin
            pix_color <= mem_rdata;
         end else if (blank_pend) begin
            pix_color <= '0;
         end

         if (clr_accept) begin
            clr_cnt   <= '0;
            clr_color <= clear_color;
         end else if (clr_step) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter.
//   dut_l : default 640x480 geometry, directed display/write checks.
//   dut_s : 8x4 geometry, checked every cycle against a behavioural model
//           (shadow RAM, clear progress, pixel latency) under directed and
//           random stimulus.
module tb_fb_arbiter;

   localparam int unsigned SH   = 8;
   localparam int unsigned SV   = 4;
   localparam int unsigned SPIX = SH * SV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        pix_en;
   logic [9:0]  hcount, vcount;
   logic        wr_req;
   logic [18:0] wr_addr_l;
   logic [5:0]  wr_addr_s;
   logic [7:0]  wr_data;
   logic        clear_start_l, clear_start_s;
   logic [7:0]  clear_color;

   logic [7:0]  pix_l, wdata_l, rdata_l;
   logic        ack_l, busy_l, done_l, we_l;
   logic [18:0] addr_l;
   logic [7:0]  pix_s, wdata_s, rdata_s;
   logic        ack_s, busy_s, done_s, we_s;
   logic [5:0]  addr_s;

   logic [7:0]  ram_l [0:524287];
   logic [7:0]  ram_s [0:63];

   always @(posedge clk) begin
      if (we_l) ram_l[addr_l] <= wdata_l;
      rdata_l <= ram_l[addr_l];
   end

   always @(posedge clk) begin
      if (we_s) ram_s[addr_s] <= wdata_s;
      rdata_s <= ram_s[addr_s];
   end

   fb_arbiter dut_l (
      .clk (clk), .reset (reset), .pix_en (pix_en), .hcount (hcount), .vcount (vcount),
      .pix_color (pix_l), .wr_req (wr_req), .wr_addr (wr_addr_l), .wr_data (wr_data),
      .wr_ack (ack_l), .clear_start (clear_start_l), .clear_color (clear_color),
      .clear_busy (busy_l), .clear_done (done_l), .mem_addr (addr_l), .mem_we (we_l),
      .mem_wdata (wdata_l), .mem_rdata (rdata_l)
   );

   fb_arbiter #(.H_ACTIVE (SH), .V_ACTIVE (SV), .ADDR_W (6), .DATA_W (8)) dut_s (
      .clk (clk), .reset (reset), .pix_en (pix_en), .hcount (hcount), .vcount (vcount),
      .pix_color (pix_s), .wr_req (wr_req), .wr_addr (wr_addr_s), .wr_data (wr_data),
      .wr_ack (ack_s), .clear_start (clear_start_s), .clear_color (clear_color),
      .clear_busy (busy_s), .clear_done (done_s), .mem_addr (addr_s), .mem_we (we_s),
      .mem_wdata (wdata_s), .mem_rdata (rdata_s)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model of dut_s
   bit          m_clr, m_done, p_valid, seen_ack_s;
   int unsigned m_cnt;
   logic [7:0]  m_col, m_pix, p_val;
   logic [7:0]  shadow [0:31];
   bit          c_disp, c_we, c_ack;
   int unsigned c_a;
   logic [5:0]  c_addr;
   logic [7:0]  c_data;

   task automatic sample();
      @(negedge clk);
      c_disp = pix_en && (32'(hcount) < SH) && (32'(vcount) < SV);
      c_a    = 32'(vcount) * SH + 32'(hcount);
      c_we   = 1'b0;
      c_ack  = 1'b0;
      c_addr = '0;
      c_data = '0;
      if (!reset) begin
         if (c_disp) begin
            c_addr = 6'(c_a);
         end else if (m_clr) begin
            c_we = 1'b1; c_addr = 6'(m_cnt); c_data = m_col;
         end else if (wr_req) begin
            c_ack = 1'b1;
            if (32'(wr_addr_s) < SPIX) begin
               c_we = 1'b1; c_addr = wr_addr_s; c_data = wr_data;
            end
         end
      end
      chk("s_ack", 32'(ack_s), 32'(c_ack));
      chk("s_we", 32'(we_s), 32'(c_we));
      if (reset || c_we || c_disp) chk("s_addr", 32'(addr_s), 32'(c_addr));
      if (reset || c_we) chk("s_wdata", 32'(wdata_s), 32'(c_data));
      chk("s_busy", 32'(busy_s), 32'(m_clr));
      chk("s_done", 32'(done_s), 32'(m_done));
      chk("s_pix", 32'(pix_s), 32'(m_pix));
      seen_ack_s = ack_s;
   endtask

   task automatic advance();
      bit was;
      @(posedge clk);
      if (reset) begin
         m_clr = 0; m_done = 0; m_cnt = 0; m_pix = '0; p_valid = 0;
      end else begin
         if (p_valid) m_pix = p_val;
         p_valid = pix_en;
         p_val   = c_disp ? shadow[c_addr[4:0]] : 8'h00;
         if (c_we) shadow[c_addr[4:0]] = c_data;
         was    = m_clr;
         m_done = 0;
         if (was && !c_disp) begin
            if (m_cnt == SPIX - 1) begin
               m_clr = 0; m_done = 1;
            end
            m_cnt++;
         end
         if (!was && clear_start_s) begin
            m_clr = 1; m_cnt = 0; m_col = clear_color;
         end
      end
      #1;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
      $fatal(1);
   end

   initial begin
      int n_wr, ack_at;
      bit got;

      reset = 1; pix_en = 0; hcount = '0; vcount = '0;
      wr_req = 1; wr_addr_l = 19'd5; wr_addr_s = 6'd5; wr_data = 8'h3C;
      clear_start_l = 1; clear_start_s = 1; clear_color = 8'hEE;

      // Reset held with requests pending
      repeat (3) begin
         sample();
         chk("rst_pix", 32'(pix_l), 0);
         chk("rst_ack", 32'(ack_l), 0);
         chk("rst_we", 32'(we_l), 0);
         chk("rst_addr", 32'(addr_l), 0);
         chk("rst_wdata", 32'(wdata_l), 0);
         chk("rst_busy", 32'(busy_l), 0);
         chk("rst_done", 32'(done_l), 0);
         advance();
      end
      reset = 0; wr_req = 0; clear_start_l = 0; clear_start_s = 0;
      sample();
      chk("rel_busy", 32'(busy_l), 0);
      advance();

      // Full clear of the 8x4 frame with a writer waiting throughout
      clear_start_s = 1; clear_color = 8'h7F; wr_addr_l = '0;
      cyc();
      clear_start_s = 0; wr_req = 1; wr_addr_s = 6'd3; wr_data = 8'h11;
      n_wr = 0; ack_at = -1;
      for (int i = 1; i <= 40; i++) begin
         sample();
         if (we_s && busy_s) n_wr++;
         if (ack_s) begin
            ack_at = i;
            chk("clr_done_with_ack", 32'(done_s), 1);
         end
         advance();
         if (ack_at >= 0) break;
      end
      wr_req = 0;
      chk("clr_writes", 32'(n_wr), 32);
      chk("clr_ack_cycle", 32'(ack_at), 33);
      cyc();
      for (int i = 0; i < 32; i++)
         chk("ram_clr", 32'(ram_s[i]), (i == 3) ? 32'h11 : 32'h7F);

      // Reset with the clear counter at 10, then restart
      clear_start_s = 1; clear_color = 8'h5A;
      cyc();
      clear_start_s = 0;
      repeat (10) cyc();
      reset = 1;
      cyc();
      reset = 0;
      sample();
      chk("abort_busy", 32'(busy_s), 0);
      advance();
      repeat (40) cyc();
      clear_start_s = 1; clear_color = 8'h22;
      cyc();
      clear_start_s = 0;
      sample();
      chk("restart_addr0", 32'(addr_s), 0);
      chk("restart_we", 32'(we_s), 1);
      advance();
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         sample();
         got = done_s;
         advance();
      end
      chk("restart_done", 32'(got), 1);

      // 640x480: preload RAM[641] and read it back through the display
      wr_req = 1; wr_addr_l = 19'd641; wr_addr_s = 6'd0; wr_data = 8'hA5;
      sample();
      chk("pre_ack", 32'(ack_l), 1);
      chk("pre_we", 32'(we_l), 1);
      chk("pre_addr", 32'(addr_l), 641);
      chk("pre_wdata", 32'(wdata_l), 32'hA5);
      advance();
      wr_req = 0;
      pix_en = 1; hcount = 10'd1; vcount = 10'd1;
      sample();
      chk("disp_addr", 32'(addr_l), 641);
      chk("disp_we", 32'(we_l), 0);
      advance();
      pix_en = 0;
      sample();
      chk("disp_t1", 32'(pix_l), 0);
      advance();
      sample();
      chk("disp_t2", 32'(pix_l), 32'hA5);
      advance();

      // Contention: writer held across a display strobe
      wr_req = 1; wr_addr_l = 19'd5; wr_addr_s = 6'd5; wr_data = 8'h3C;
      pix_en = 1; hcount = 10'd2; vcount = 10'd0;
      sample();
      chk("cont_noack", 32'(ack_l), 0);
      chk("cont_addr", 32'(addr_l), 2);
      advance();
      pix_en = 0;
      sample();
      chk("cont_ack", 32'(ack_l), 1);
      chk("cont_we", 32'(we_l), 1);
      chk("cont_waddr", 32'(addr_l), 5);
      chk("cont_wdata", 32'(wdata_l), 32'h3C);
      advance();
      wr_req = 0;
      pix_en = 1; hcount = 10'd5;
      cyc();
      pix_en = 0;
      cyc();
      sample();
      chk("cont_read", 32'(pix_l), 32'h3C);
      advance();
      cyc(); cyc();
      sample();
      chk("pix_hold", 32'(pix_l), 32'h3C);
      advance();

      // Address range boundaries
      wr_req = 1; wr_addr_l = 19'd307200; wr_data = 8'h44;
      sample();
      chk("oor_ack", 32'(ack_l), 1);
      chk("oor_we", 32'(we_l), 0);
      advance();
      wr_addr_l = 19'd307199; wr_data = 8'h99;
      sample();
      chk("last_ack", 32'(ack_l), 1);
      chk("last_we", 32'(we_l), 1);
      chk("last_addr", 32'(addr_l), 307199);
      advance();
      wr_req = 0;
      pix_en = 1; hcount = 10'd639; vcount = 10'd479;
      sample();
      chk("corner_addr", 32'(addr_l), 307199);
      advance();
      hcount = 10'd640; vcount = 10'd0;
      sample();
      chk("blank_we", 32'(we_l), 0);
      advance();
      pix_en = 0;
      sample();
      chk("corner_pix", 32'(pix_l), 32'h99);
      advance();
      sample();
      chk("blank_pix", 32'(pix_l), 0);
      advance();

      // Random traffic on the small frame
      wr_addr_l = '0;
      for (int i = 0; i < 400; i++) begin
         if (!wr_req || seen_ack_s) begin
            wr_req    = 1'($urandom_range(0, 1));
            wr_addr_s = 6'($urandom_range(0, 40));
            wr_data   = 8'($urandom);
         end
         pix_en        = 1'($urandom_range(0, 1));
         hcount        = 10'($urandom_range(0, 9));
         vcount        = 10'($urandom_range(0, 5));
         clear_start_s = ($urandom_range(0, 59) == 0);
         clear_color   = 8'($urandom);
         cyc();
      end
      wr_req = 0; pix_en = 0; clear_start_s = 0;
      for (int i = 0; i < 40 && m_clr; i++) cyc();
      chk("rand_clear_end", 32'(m_clr), 0);
      cyc();
      for (int i = 0; i < 32; i++)
         chk("ram_rand", 32'(ram_s[i]), 32'(shadow[i]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two users: the VGA scan-out reader, which is real-time and has absolute priority, and a pixel writer such as a drawing engine or CPU.
- Also sequences a hardware clear: a full-frame fill with a constant colour.
- Sits between the hcount/vcount timing from VGA_Controller and the imageDrawer/colour path; supplies the 8-bit colour fed to r/g/b.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- DATA_W, 8, pixel width

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel strobe (25 MHz rate at 50 MHz clk)
- hcount  in  10  current pixel column
- vcount  in  10  current line
- pix_color  out  DATA_W  registered colour for the display
- wr_req  in  1  write request; wr_addr/wr_data held stable until ack
- wr_addr  in  ADDR_W  linear pixel address
- wr_data  in  DATA_W  pixel value
- wr_ack  out  1  one-cycle pulse: request consumed
- clear_start  in  1  pulse: begin full-frame fill
- clear_color  in  DATA_W  fill value, sampled on the accepted clear_start
- clear_busy  out  1  fill in progress
- clear_done  out  1  one-cycle pulse at fill completion
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset state: pix_color=0, wr_ack=0, clear_busy=0, clear_done=0, mem_we=0, mem_addr=0, mem_wdata=0; FSM=IDLE; clear counter=0.
- Reset asserted mid-clear aborts the fill; no clear_done is produced.
- Slot rule, per cycle:
  - Display slot when pix_en=1, hcount<H_ACTIVE and vcount<V_ACTIVE.
  - Every other cycle is a write slot.
- Display slot:
  - mem_addr = vcount*H_ACTIVE + hcount, computed at ADDR_W width with no truncation; mem_we=0.
  - pix_color is updated from mem_rdata at the end of the following cycle, i.e. visible 2 cycles after the strobe.
- pix_en=1 outside the active area: no read issued; pix_color loads 0 with the same 2-cycle latency.
- Without pix_en, pix_color holds its value.
- FSM IDLE:
  - A write slot with wr_req=1 grants the writer.
  - If wr_addr < H_ACTIVE*V_ACTIVE: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data.
  - Otherwise the write is discarded with mem_we=0.
  - wr_ack=1 in the grant cycle in both cases.
  - clear_start=1: latch clear_color, counter=0, next state CLEAR. The writer may still be granted in that same cycle.
- FSM CLEAR:
  - clear_busy=1.
  - Every write slot: mem_addr=counter, mem_we=1, mem_wdata=latched colour, counter++.
  - Writer is never granted; wr_ack=0 and the request is held off.
  - clear_start is ignored.
  - After writing address H_ACTIVE*V_ACTIVE-1: next state IDLE, clear_done=1 for one cycle, clear_busy=0 in that same cycle.
- Display slots are never stolen. Writer and clear progress only on write slots, so the display never misses a read.
- Back-to-back writes: one grant per write slot is allowed. wr_ack is high only on grant cycles, never two acks for one held request unless the writer deasserts and re-asserts or presents new data. The writer samples the ack and advances.
- Simultaneous display slot and wr_req: the display wins; the writer waits.

Decomposition:
- Shared package fb_pkg:
  - localparam FB_PIXELS = H_ACTIVE*V_ACTIVE
  - typedefs for pixel_t (DATA_W) and fb_addr_t (ADDR_W)
  - state enum {IDLE, CLEAR}
- One natural sub-module, fb_addr_gen: combinational hcount/vcount to linear address plus the in-active flag, reusable by imageDrawer.

Test Plan:
- Reset: hold reset 3 cycles with wr_req=1 and clear_start=1 -> all outputs 0, no mem_we, FSM IDLE on release.
- Display read: preload RAM[641]=0xA5; strobe pix_en with hcount=1, vcount=1 at cycle t -> mem_addr=641 at t, pix_color=0xA5 from t+2.
- Contention: wr_req with addr=5, data=0x3C, held over pix_en=1 in the active area -> no ack in the strobe cycle; ack on the next non-strobe cycle; RAM[5]=0x3C; display reads unaffected.
- Out-of-range write: wr_addr=307200 -> wr_ack pulse, mem_we stays 0.
- Clear, bench with H_ACTIVE=8, V_ACTIVE=4, pix_en=0:
  - clear_start with colour 0x7F -> 32 consecutive writes, addr 0..31.
  - clear_done pulses in the cycle after the last write.
  - A wr_req pending throughout the fill is acked only after clear_done.
- Reset at clear counter=10 -> clear_busy=0 next cycle, no clear_done; a subsequent clear_start restarts from addr 0.
